// File: rtl/imm_gen_unit_pkg.sv
// imm_gen_unit_pkg: shared immediate-format encodings and width constants
package imm_gen_unit_pkg;

    localparam int INST_W = 25;
    localparam int XLEN   = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b101,
        IMM_J = 3'b110
    } imm_src_t;

    function automatic logic imm_src_valid(input logic [2:0] s);
        return (s == IMM_I) || (s == IMM_S) || (s == IMM_B) || (s == IMM_U) || (s == IMM_J);
    endfunction

endpackage

// File: rtl/imm_gen_unit_if.sv
// imm_gen_unit_if: decoder-to-immediate-generator bundle
interface imm_gen_unit_if;
    import imm_gen_unit_pkg::*;

    logic [INST_W-1:0] Inst;
    logic [2:0]        ImmSrc;
    logic [XLEN-1:0]   ImmExt;
    logic              ImmErr;

    modport master (output Inst, output ImmSrc, input ImmExt, input ImmErr);
    modport slave  (input Inst, input ImmSrc, output ImmExt, output ImmErr);

endinterface

// File: rtl/imm_gen_unit_mux.sv
// imm_gen_mux: combinational RV32I immediate format selection and sign extension
module imm_gen_mux
    import imm_gen_unit_pkg::*;
(
    input  logic [INST_W-1:0] inst,
    input  logic [2:0]        imm_src,
    output logic [XLEN-1:0]   imm_ext
);

    // inst[24] is instr[31], the sign bit for every format; undefined selects give zero
    always_comb begin
        imm_ext = (imm_src == IMM_I) ? {{20{inst[24]}}, inst[24:13]} :
                  (imm_src == IMM_S) ? {{20{inst[24]}}, inst[24:18], inst[4:0]} :
                  (imm_src == IMM_B) ? {{19{inst[24]}}, inst[24], inst[0], inst[23:18], inst[4:1], 1'b0} :
                  (imm_src == IMM_U) ? {inst[24:5], 12'b0} :
                  (imm_src == IMM_J) ? {{11{inst[24]}}, inst[24], inst[12:5], inst[13], inst[23:14], 1'b0} :
                  '0;
    end

endmodule

// File: rtl/imm_gen_unit.sv
// imm_gen_unit: immediate generator with sticky undefined-select flag; IMM_GEN_OUT_REG_EN registers ImmExt
module imm_gen_unit
    import imm_gen_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    imm_gen_unit_if.slave bus
);

    logic [XLEN-1:0] ext_d;
    logic            err_d;
    logic            err_q;

    imm_gen_mux u_mux (
        .inst    (bus.Inst),
        .imm_src (bus.ImmSrc),
        .imm_ext (ext_d)
    );

    // the error flag only ever sets; reset is the sole way to clear it
    always_comb begin
        err_d = err_q | ~imm_src_valid(bus.ImmSrc);
    end

    // sticky error flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign bus.ImmErr = err_q;

`ifdef IMM_GEN_OUT_REG_EN
    logic [XLEN-1:0] ext_q;

    // optional output register for timing closure downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ext_q <= '0;
        else        ext_q <= ext_d;
    end

    assign bus.ImmExt = ext_q;
`else
    assign bus.ImmExt = ext_d;
`endif

endmodule

// File: tb/tb_imm_gen_unit.sv
// tb_imm_gen_unit: directed table-driven bench for imm_gen_unit
module tb_imm_gen_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;

    imm_gen_unit_if bus();

    imm_gen_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  src;
        logic [24:0] inst;
        logic [31:0] ext;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic apply(input logic [2:0] src, input logic [24:0] inst);
        @(negedge clk);
        bus.ImmSrc = src;
        bus.Inst   = inst;
    endtask

    task automatic settle();
`ifdef IMM_GEN_OUT_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{"i_pos",  3'b000, 25'b0000000111100000000001010, 32'h0000001E};
        vecs[1] = '{"s_pos",  3'b001, 25'b0000000100100001001001000, 32'h00000008};
        vecs[2] = '{"u_mix",  3'b101, 25'b1111111000000000010110101, 32'hFE005000};
        vecs[3] = '{"b_pos",  3'b010, 25'b0000001100000011100100001, 32'h00000820};
        vecs[4] = '{"j_pos",  3'b110, 25'b0000010010000000000000001, 32'h00000048};
        vecs[5] = '{"i_min",  3'b000, 25'h1000000,                   32'hFFFFF800};
        vecs[6] = '{"s_ones", 3'b001, 25'h1FFFFFF,                   32'hFFFFFFFF};
        vecs[7] = '{"b_ones", 3'b010, 25'h1FFFFFF,                   32'hFFFFFFFE};
        vecs[8] = '{"u_ones", 3'b101, 25'h1FFFFFF,                   32'hFFFFF000};
        vecs[9] = '{"j_ones", 3'b110, 25'h1FFFFFF,                   32'hFFFFFFFE};

        bus.ImmSrc = 3'b111;
        bus.Inst   = '0;
        #1;
        chk("reset_err", {31'b0, bus.ImmErr}, 32'd0);
`ifdef IMM_GEN_OUT_REG_EN
        chk("reset_ext", bus.ImmExt, 32'd0);
`endif
        edge_wait();
        chk("err_held_in_reset", {31'b0, bus.ImmErr}, 32'd0);
        @(negedge clk);
        bus.ImmSrc = 3'b000;
        rst_n = 1'b1;
        edge_wait();
        chk("err_after_release", {31'b0, bus.ImmErr}, 32'd0);

        foreach (vecs[k]) begin
            apply(vecs[k].src, vecs[k].inst);
            settle();
            chk({vecs[k].name, "_ext"}, bus.ImmExt, vecs[k].ext);
            chk({vecs[k].name, "_err"}, {31'b0, bus.ImmErr}, 32'd0);
        end

        apply(3'b000, 25'h1FFE000);
        settle();
        chk("i_neg_ext", bus.ImmExt, 32'hFFFFFFFF);

        @(posedge clk);
        #2;
        bus.ImmSrc = 3'b111;
        #2;
        bus.ImmSrc = 3'b000;
        edge_wait();
        chk("glitch_not_sampled", {31'b0, bus.ImmErr}, 32'd0);

        apply(3'b111, 25'h1FFE000);
        settle();
        chk("undef_ext", bus.ImmExt, 32'd0);
`ifndef IMM_GEN_OUT_REG_EN
        chk("undef_err_before_edge", {31'b0, bus.ImmErr}, 32'd0);
        edge_wait();
`endif
        chk("undef_err_set", {31'b0, bus.ImmErr}, 32'd1);
        apply(3'b000, 25'h1FFE000);
        edge_wait();
        edge_wait();
        chk("err_sticky", {31'b0, bus.ImmErr}, 32'd1);
        chk("ext_back_to_i", bus.ImmExt, 32'hFFFFFFFF);

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_clear_err", {31'b0, bus.ImmErr}, 32'd0);
`ifdef IMM_GEN_OUT_REG_EN
        chk("async_clear_ext", bus.ImmExt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        apply(3'b011, '0);
        edge_wait();
        chk("undef_011_err", {31'b0, bus.ImmErr}, 32'd1);
        chk("undef_011_ext", bus.ImmExt, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.ImmSrc = 3'b100;
        bus.Inst = 25'h1FFFFFF;
        #1;
        chk("clear_again", {31'b0, bus.ImmErr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        edge_wait();
        chk("undef_100_err", {31'b0, bus.ImmErr}, 32'd1);
        chk("undef_100_ext", bus.ImmExt, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
